sudoku_game_core: RTL and testbench

//  Parametrised game-logic core for an N x N Sudoku (N = BOX*BOX) with a one-board cursor/write engine.

---
 rtl/sudoku_pkg.sv | 47 ++++
 rtl/sudoku_solve_checker.sv | 98 +++++++++
 rtl/sudoku_game_core.sv | 149 ++++++++++++++
 tb/tb_sudoku_game_core.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared key codes, checker state encoding and scan helpers for the Sudoku game core.
package sudoku_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [3:0] {
        KEY_NONE  = 4'd0,
        KEY_UP    = 4'd1,
        KEY_DOWN  = 4'd2,
        KEY_LEFT  = 4'd3,
        KEY_RIGHT = 4'd4,
        KEY_WRITE = 4'd5,
        KEY_CLEAR = 4'd6,
        KEY_UNDO  = 4'd7
    } key_t;

    // Encoding is consecutive so the scan phases can step with +1.
    typedef enum logic [2:0] {
        CHK_IDLE  = 3'd0,
        CHK_ROWS  = 3'd1,
        CHK_COLS  = 3'd2,
        CHK_BOXES = 3'd3,
        CHK_DONE  = 3'd4
    } chk_state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } box_org_t;

    function automatic box_org_t box_origin(input logic [3:0] g, input int box);
        box_org_t o;
        o.row = 4'((32'(g) / box) * box);
        o.col = 4'((32'(g) % box) * box);
        return o;
    endfunction

    // Empty or out-of-range values contribute no bit, so they make the group fail.
    function automatic logic [MAX_N-1:0] onehot(input logic [4:0] value, input int n);
        logic [MAX_N-1:0] m;
        m = '0;
        if (value != 5'd0 && 32'(value) <= n)
            m = MAX_N'(1) << (value - 5'd1);
        return m;
    endfunction

endpackage

// File: rtl/sudoku_solve_checker.sv
// Sequential row/column/box validity scan, one group per cycle.
// state | meaning
// IDLE  | waiting for start (board dirty)
// ROWS  | scanning row g
// COLS  | scanning column g
// BOXES | scanning box g
// DONE  | report pass for one cycle, back to IDLE
module sudoku_solve_checker
    import sudoku_pkg::*;
#(
    parameter  int BOX    = 3,
    localparam int N      = BOX * BOX,
    localparam int CELL_W = $clog2(N + 1),
    localparam int IDX_W  = $clog2(N)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [N-1:0][N-1:0][CELL_W-1:0]  grid,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             pass
);

    localparam logic [MAX_N-1:0] FULL = MAX_N'((33'd1 << N) - 33'd1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    chk_state_t       state;
    logic [IDX_W-1:0] g;
    logic             fail;
    logic [MAX_N-1:0] mask;
    box_org_t         org;
    logic [IDX_W-1:0] row_sel;
    logic [IDX_W-1:0] col_sel;

    always_comb begin
        org     = box_origin(4'(g), BOX);
        mask    = '0;
        row_sel = '0;
        col_sel = '0;
        for (int a = 0; a < N; a++) begin
            case (state)
                CHK_ROWS: begin
                    row_sel = g;
                    col_sel = IDX_W'(a);
                end
                CHK_COLS: begin
                    row_sel = IDX_W'(a);
                    col_sel = g;
                end
                default: begin
                    row_sel = IDX_W'(org.row) + IDX_W'(a / BOX);
                    col_sel = IDX_W'(org.col) + IDX_W'(a % BOX);
                end
            endcase
            mask = mask | onehot(5'(grid[row_sel][col_sel]), N);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CHK_IDLE;
            g     <= '0;
            fail  <= 1'b0;
        end else if (abort) begin
            state <= CHK_IDLE;
            g     <= '0;
        end else begin
            case (state)
                CHK_IDLE: begin
                    if (start) begin
                        state <= CHK_ROWS;
                        g     <= '0;
                        fail  <= 1'b0;
                    end
                end
                CHK_ROWS, CHK_COLS, CHK_BOXES: begin
                    if (mask != FULL)
                        fail <= 1'b1;
                    if (g == LAST) begin
                        g     <= '0;
                        state <= chk_state_t'(state + 3'd1);
                    end else begin
                        g <= g + IDX_W'(1);
                    end
                end
                CHK_DONE: state <= CHK_IDLE;
                default:  state <= CHK_IDLE;
            endcase
        end
    end

    assign busy = (state != CHK_IDLE);
    assign done = (state == CHK_DONE) && !abort;
    assign pass = !fail;

endmodule

// File: rtl/sudoku_game_core.sv
// Sudoku board, cursor and write engine with a background solve checker.
// Optional one-entry undo is built when SUDOKU_UNDO_EN is defined.
module sudoku_game_core
    import sudoku_pkg::*;
#(
    parameter  int BOX    = 3,
    localparam int N      = BOX * BOX,
    localparam int CELL_W = $clog2(N + 1),
    localparam int IDX_W  = $clog2(N)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             board_load,
    input  logic [N-1:0][N-1:0][CELL_W-1:0]  initial_board,
    input  logic [N-1:0][N-1:0]              initial_given,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic [CELL_W-1:0]                user_value,
    output logic [N-1:0][N-1:0][CELL_W-1:0]  display_grid,
    output logic [N-1:0][N-1:0]              given_mask,
    output logic [IDX_W-1:0]                 cursor_i,
    output logic [IDX_W-1:0]                 cursor_j,
    output logic                             write_reject,
    output logic                             check_busy,
    output logic                             solved
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic              key_go;
    logic              cur_given;
    logic              write_ok;
    logic              clear_ok;
    logic              undo_ok;
    logic              undo_rej;
    logic              store;
    logic              dirty;
    logic              chk_done;
    logic              chk_pass;
    logic [IDX_W-1:0]  st_i;
    logic [IDX_W-1:0]  st_j;
    logic [CELL_W-1:0] st_val;

    // A load in the same cycle swallows the key.
    assign key_go    = key_valid && !board_load;
    assign cur_given = given_mask[cursor_i][cursor_j];
    assign write_ok  = key_go && (key_code == KEY_WRITE) && !cur_given
                       && (user_value != '0) && (user_value <= CELL_W'(N));
    assign clear_ok  = key_go && (key_code == KEY_CLEAR) && !cur_given;

`ifdef SUDOKU_UNDO_EN
    logic [IDX_W-1:0]  undo_i;
    logic [IDX_W-1:0]  undo_j;
    logic [CELL_W-1:0] undo_old;
    logic              undo_valid;

    assign undo_ok  = key_go && (key_code == KEY_UNDO) && undo_valid;
    assign undo_rej = key_go && (key_code == KEY_UNDO) && !undo_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            undo_i     <= '0;
            undo_j     <= '0;
            undo_old   <= '0;
            undo_valid <= 1'b0;
        end else if (board_load) begin
            undo_valid <= 1'b0;
        end else if (write_ok || clear_ok) begin
            undo_i     <= cursor_i;
            undo_j     <= cursor_j;
            undo_old   <= display_grid[cursor_i][cursor_j];
            undo_valid <= 1'b1;
        end else if (undo_ok) begin
            undo_valid <= 1'b0;
        end
    end

    assign st_i   = undo_ok ? undo_i : cursor_i;
    assign st_j   = undo_ok ? undo_j : cursor_j;
    assign st_val = undo_ok ? undo_old : (write_ok ? user_value : '0);
`else
    assign undo_ok  = 1'b0;
    assign undo_rej = 1'b0;
    assign st_i     = cursor_i;
    assign st_j     = cursor_j;
    assign st_val   = write_ok ? user_value : '0;
`endif

    assign store = write_ok || clear_ok || undo_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            display_grid <= '0;
            given_mask   <= '0;
            cursor_i     <= '0;
            cursor_j     <= '0;
            write_reject <= 1'b0;
            dirty        <= 1'b0;
            solved       <= 1'b0;
        end else begin
            write_reject <= key_go && (((key_code == KEY_WRITE) && !write_ok)
                                    || ((key_code == KEY_CLEAR) && cur_given)
                                    || undo_rej);
            if (board_load) begin
                display_grid <= initial_board;
                given_mask   <= initial_given;
                cursor_i     <= '0;
                cursor_j     <= '0;
            end else begin
                if (store)
                    display_grid[st_i][st_j] <= st_val;
                if (undo_ok) begin
                    cursor_i <= st_i;
                    cursor_j <= st_j;
                end else if (key_go) begin
                    case (key_code)
                        KEY_UP:    cursor_i <= (cursor_i == '0)  ? LAST : cursor_i - IDX_W'(1);
                        KEY_DOWN:  cursor_i <= (cursor_i == LAST) ? '0  : cursor_i + IDX_W'(1);
                        KEY_LEFT:  cursor_j <= (cursor_j == '0)  ? LAST : cursor_j - IDX_W'(1);
                        KEY_RIGHT: cursor_j <= (cursor_j == LAST) ? '0  : cursor_j + IDX_W'(1);
                        default: ;
                    endcase
                end
            end
            // Any board change invalidates the verdict and restarts the scan.
            if (board_load || store) begin
                dirty  <= 1'b1;
                solved <= 1'b0;
            end else begin
                if (dirty && !check_busy)
                    dirty <= 1'b0;
                if (chk_done)
                    solved <= chk_pass;
            end
        end
    end

    sudoku_solve_checker #(.BOX(BOX)) u_checker (
        .clock   (clock),
        .reset_n (reset_n),
        .grid    (display_grid),
        .start   (dirty),
        .abort   (board_load || store),
        .busy    (check_busy),
        .done    (chk_done),
        .pass    (chk_pass)
    );

endmodule

// File: tb/tb_sudoku_game_core.sv
// Scoreboard bench for sudoku_game_core (BOX = 3): cursor, write protection, solve latency, undo.
`timescale 1ns/1ps
module tb_sudoku_game_core;
    import sudoku_pkg::*;

    localparam int BOX    = 3;
    localparam int N      = 9;
    localparam int CELL_W = 4;
    localparam int IDX_W  = 4;

    typedef logic [N-1:0][N-1:0][CELL_W-1:0] grid_t;
    typedef logic [N-1:0][N-1:0]             mask_t;

    typedef struct {
        string tag;
        int    ci;
        int    cj;
        bit    rej;
        grid_t grid;
        mask_t given;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              board_load = 1'b0;
    grid_t             initial_board = '0;
    mask_t             initial_given = '0;
    logic              key_valid = 1'b0;
    logic [3:0]        key_code = 4'd0;
    logic [CELL_W-1:0] user_value = '0;
    grid_t             display_grid;
    mask_t             given_mask;
    logic [IDX_W-1:0]  cursor_i;
    logic [IDX_W-1:0]  cursor_j;
    logic              write_reject;
    logic              check_busy;
    logic              solved;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    grid_t             m_grid = '0;
    mask_t             m_given = '0;
    int                m_ci = 0;
    int                m_cj = 0;
    bit                m_uv = 0;
    int                m_ui = 0;
    int                m_uj = 0;
    logic [CELL_W-1:0] m_uo = '0;

    always #5 clock = ~clock;

    sudoku_game_core #(.BOX(BOX)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .board_load    (board_load),
        .initial_board (initial_board),
        .initial_given (initial_given),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .user_value    (user_value),
        .display_grid  (display_grid),
        .given_mask    (given_mask),
        .cursor_i      (cursor_i),
        .cursor_j      (cursor_j),
        .write_reject  (write_reject),
        .check_busy    (check_busy),
        .solved        (solved)
    );

    function automatic grid_t valid_grid();
        grid_t g;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                g[r][c] = CELL_W'(((r * BOX + r / BOX + c) % N) + 1);
        return g;
    endfunction

    function automatic exp_t snap(input string tag, input bit rej);
        exp_t e;
        e.tag = tag; e.ci = m_ci; e.cj = m_cj; e.rej = rej;
        e.grid = m_grid; e.given = m_given;
        return e;
    endfunction

    // Drive one key for one cycle; the reference model predicts the result.
    task automatic press(input string tag, input logic [3:0] k, input int v);
        bit rej;
        @(negedge clock);
        key_valid = 1'b1; key_code = k; user_value = CELL_W'(v);
        rej = 0;
        case (k)
            4'd1: m_ci = (m_ci == 0) ? N - 1 : m_ci - 1;
            4'd2: m_ci = (m_ci == N - 1) ? 0 : m_ci + 1;
            4'd3: m_cj = (m_cj == 0) ? N - 1 : m_cj - 1;
            4'd4: m_cj = (m_cj == N - 1) ? 0 : m_cj + 1;
            4'd5, 4'd6: begin
                if (m_given[m_ci][m_cj] || (k == 4'd5 && (v < 1 || v > N))) begin
                    rej = 1;
                end else begin
                    m_uv = 1; m_ui = m_ci; m_uj = m_cj; m_uo = m_grid[m_ci][m_cj];
                    m_grid[m_ci][m_cj] = (k == 4'd5) ? CELL_W'(v) : '0;
                end
            end
`ifdef SUDOKU_UNDO_EN
            4'd7: begin
                if (m_uv) begin
                    m_grid[m_ui][m_uj] = m_uo; m_ci = m_ui; m_cj = m_uj; m_uv = 0;
                end else begin
                    rej = 1;
                end
            end
`endif
            default: ;
        endcase
        sb.push_back(snap(tag, rej));
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic load(input string tag, input grid_t b, input mask_t gv, input bit with_key);
        @(negedge clock);
        board_load = 1'b1; initial_board = b; initial_given = gv;
        if (with_key) begin
            key_valid = 1'b1; key_code = KEY_WRITE; user_value = CELL_W'(3);
        end
        m_grid = b; m_given = gv; m_ci = 0; m_cj = 0; m_uv = 0;
        sb.push_back(snap(tag, 0));
        @(negedge clock);
        board_load = 1'b0; key_valid = 1'b0;
    endtask

    // Edges from the last board change until the checker goes idle again.
    task automatic run_check(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            lat++;
            if (check_busy) busy_n++;
            else if (busy_n > 0) break;
        end
    endtask

    task automatic test_reset();
        total_cnt++;
        if (display_grid !== '0 || given_mask !== '0 || cursor_i !== '0 || cursor_j !== '0
            || write_reject !== 1'b0 || check_busy !== 1'b0 || solved !== 1'b0)
            $display("FAIL reset: grid=%h given=%h cur=(%0d,%0d) rej=%0b busy=%0b solved=%0b, all zero required",
                     display_grid, given_mask, cursor_i, cursor_j, write_reject, check_busy, solved);
        else pass_cnt++;
    endtask

    task automatic test_cursor();
        logic [3:0] keys[14] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4,
                                 4'd1, 4'd3, 4'd2, 4'd9, 4'd7};
        exp_t e;
        for (int n = 0; n < 14; n++) begin
            press($sformatf("cursor_%0d", n), keys[n], 0);
            e = sb.pop_front(); total_cnt++;
            if (cursor_i !== IDX_W'(e.ci) || cursor_j !== IDX_W'(e.cj) || write_reject !== e.rej
                || display_grid !== e.grid || given_mask !== e.given)
                $display("FAIL %s: got cur=(%0d,%0d) rej=%0b, want cur=(%0d,%0d) rej=%0b",
                         e.tag, cursor_i, cursor_j, write_reject, e.ci, e.cj, e.rej);
            else pass_cnt++;
            if (n == 8) begin
                total_cnt++;
                if (cursor_j !== '0) $display("FAIL right_wrap: got j=%0d want 0", cursor_j);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_write_protect();
        grid_t b = '0;
        mask_t gv = '0;
        logic [3:0] keys[10] = '{4'd5, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd3, 4'd6, 4'd4};
        int vals[10] = '{7, 0, 10, 0, 3, 3, 0, 0, 0, 0};
        exp_t e;
        b[0][0] = CELL_W'(5); gv[0][0] = 1'b1;
        load("wp_load", b, gv, 0);
        e = sb.pop_front(); total_cnt++;
        if (display_grid !== e.grid || given_mask !== e.given || cursor_i !== '0 || cursor_j !== '0)
            $display("FAIL wp_load: got grid=%h given=%h, want grid=%h given=%h", display_grid, given_mask, e.grid, e.given);
        else pass_cnt++;
        for (int n = 0; n < 10; n++) begin
            press($sformatf("wp_%0d", n), keys[n], vals[n]);
            e = sb.pop_front(); total_cnt++;
            if (cursor_i !== IDX_W'(e.ci) || cursor_j !== IDX_W'(e.cj) || write_reject !== e.rej
                || display_grid !== e.grid)
                $display("FAIL %s: got cur=(%0d,%0d) rej=%0b grid=%h, want cur=(%0d,%0d) rej=%0b grid=%h",
                         e.tag, cursor_i, cursor_j, write_reject, display_grid, e.ci, e.cj, e.rej, e.grid);
            else pass_cnt++;
            if (n == 0) begin
                total_cnt++;
                if (write_reject !== 1'b1 || display_grid[0][0] !== CELL_W'(5))
                    $display("FAIL given_write: got rej=%0b cell=%0d, want rej=1 cell=5", write_reject, display_grid[0][0]);
                else pass_cnt++;
            end
        end
        press("wp_write9", KEY_WRITE, 9);
        e = sb.pop_front(); total_cnt++;
        if (write_reject !== e.rej || display_grid !== e.grid)
            $display("FAIL %s: got rej=%0b grid=%h, want rej=%0b grid=%h", e.tag, write_reject, display_grid, e.rej, e.grid);
        else pass_cnt++;
    endtask

    task automatic test_solve();
        grid_t b;
        int lat, busy_n;
        exp_t e;
        b = valid_grid();
        load("solve_load", b, '0, 0);
        e = sb.pop_front(); total_cnt++;
        if (display_grid !== e.grid || solved !== 1'b0)
            $display("FAIL %s: got grid=%h solved=%0b, want grid=%h solved=0", e.tag, display_grid, solved, e.grid);
        else pass_cnt++;
        run_check(lat, busy_n);
        total_cnt++;
        if (lat !== 3 * N + 2 || busy_n !== 3 * N + 1 || solved !== 1'b1)
            $display("FAIL solve_valid: got lat=%0d busy=%0d solved=%0b, want lat=%0d busy=%0d solved=1",
                     lat, busy_n, solved, 3 * N + 2, 3 * N + 1);
        else pass_cnt++;
        b[0][0] = valid_grid()[0][1];
        b[0][1] = valid_grid()[0][0];
        load("swap_load", b, '0, 0);
        e = sb.pop_front(); total_cnt++;
        if (display_grid !== e.grid || solved !== 1'b0)
            $display("FAIL %s: got grid=%h solved=%0b, want grid=%h solved=0", e.tag, display_grid, solved, e.grid);
        else pass_cnt++;
        run_check(lat, busy_n);
        total_cnt++;
        if (lat !== 3 * N + 2 || solved !== 1'b0)
            $display("FAIL solve_swapped: got lat=%0d solved=%0b, want lat=%0d solved=0", lat, solved, 3 * N + 2);
        else pass_cnt++;
    endtask

    task automatic test_write_solve();
        grid_t b;
        mask_t gv;
        logic [CELL_W-1:0] good;
        int lat, busy_n;
        exp_t e;
        b = valid_grid(); good = b[4][4]; b[4][4] = '0;
        gv = '1; gv[4][4] = 1'b0;
        load("ws_load", b, gv, 0);
        void'(sb.pop_front());
        for (int n = 0; n < 8; n++) begin
            press($sformatf("ws_move_%0d", n), (n < 4) ? KEY_DOWN : KEY_RIGHT, 0);
            e = sb.pop_front(); total_cnt++;
            if (cursor_i !== IDX_W'(e.ci) || cursor_j !== IDX_W'(e.cj))
                $display("FAIL %s: got cur=(%0d,%0d) want (%0d,%0d)", e.tag, cursor_i, cursor_j, e.ci, e.cj);
            else pass_cnt++;
        end
        press("ws_write", KEY_WRITE, int'(good));
        e = sb.pop_front(); total_cnt++;
        if (display_grid !== e.grid || write_reject !== 1'b0)
            $display("FAIL %s: got grid=%h rej=%0b, want grid=%h rej=0", e.tag, display_grid, write_reject, e.grid);
        else pass_cnt++;
        run_check(lat, busy_n);
        total_cnt++;
        if (lat !== 3 * N + 2 || solved !== 1'b1)
            $display("FAIL ws_solved: got lat=%0d solved=%0b, want lat=%0d solved=1", lat, solved, 3 * N + 2);
        else pass_cnt++;
        press("ws_clear", KEY_CLEAR, 0);
        e = sb.pop_front(); total_cnt++;
        if (display_grid !== e.grid || solved !== 1'b0)
            $display("FAIL %s: got grid=%h solved=%0b, want grid=%h solved=0", e.tag, display_grid, solved, e.grid);
        else pass_cnt++;
        press("ws_rewrite1", KEY_WRITE, int'(good));
        void'(sb.pop_front());
        repeat (10) @(negedge clock);
        total_cnt++;
        if (solved !== 1'b0 || check_busy !== 1'b1)
            $display("FAIL ws_midscan: got solved=%0b busy=%0b, want solved=0 busy=1", solved, check_busy);
        else pass_cnt++;
        press("ws_rewrite2", KEY_WRITE, int'(good));
        void'(sb.pop_front());
        run_check(lat, busy_n);
        total_cnt++;
        if (lat !== 3 * N + 2 || solved !== 1'b1)
            $display("FAIL ws_restart: got lat=%0d solved=%0b, want lat=%0d solved=1", lat, solved, 3 * N + 2);
        else pass_cnt++;
    endtask

    task automatic test_load_vs_key();
        exp_t e;
        load("lk_pre", '0, '0, 0);
        void'(sb.pop_front());
        press("lk_down", KEY_DOWN, 0);
        void'(sb.pop_front());
        press("lk_right", KEY_RIGHT, 0);
        void'(sb.pop_front());
        load("lk_load_key", '0, '0, 1);
        e = sb.pop_front(); total_cnt++;
        if (cursor_i !== IDX_W'(e.ci) || cursor_j !== IDX_W'(e.cj) || write_reject !== e.rej
            || display_grid !== e.grid)
            $display("FAIL %s: got cur=(%0d,%0d) rej=%0b grid=%h, want cur=(%0d,%0d) rej=%0b grid=%h",
                     e.tag, cursor_i, cursor_j, write_reject, display_grid, e.ci, e.cj, e.rej, e.grid);
        else pass_cnt++;
    endtask

    task automatic test_undo();
        logic [3:0] keys[13] = '{4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd5, 4'd2, 4'd2, 4'd2, 4'd4, 4'd4, 4'd7, 4'd7};
        exp_t e;
        load("undo_load", '0, '0, 0);
        void'(sb.pop_front());
        for (int n = 0; n < 13; n++) begin
            press($sformatf("undo_%0d", n), keys[n], 4);
            e = sb.pop_front(); total_cnt++;
            if (cursor_i !== IDX_W'(e.ci) || cursor_j !== IDX_W'(e.cj) || write_reject !== e.rej
                || display_grid !== e.grid)
                $display("FAIL %s: got cur=(%0d,%0d) rej=%0b grid=%h, want cur=(%0d,%0d) rej=%0b grid=%h",
                         e.tag, cursor_i, cursor_j, write_reject, display_grid, e.ci, e.cj, e.rej, e.grid);
            else pass_cnt++;
            if (n == 11) begin
                total_cnt++;
`ifdef SUDOKU_UNDO_EN
                if (cursor_i !== IDX_W'(2) || cursor_j !== IDX_W'(3) || display_grid[2][3] !== '0 || write_reject !== 1'b0)
                    $display("FAIL undo_restore: got cur=(%0d,%0d) cell=%0d rej=%0b, want (2,3) cell=0 rej=0",
                             cursor_i, cursor_j, display_grid[2][3], write_reject);
`else
                if (cursor_i !== IDX_W'(5) || cursor_j !== IDX_W'(5) || display_grid[2][3] !== CELL_W'(4) || write_reject !== 1'b0)
                    $display("FAIL undo_ignored: got cur=(%0d,%0d) cell=%0d rej=%0b, want (5,5) cell=4 rej=0",
                             cursor_i, cursor_j, display_grid[2][3], write_reject);
`endif
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        load("rst_load", valid_grid(), '0, 0);
        void'(sb.pop_front());
        repeat (5) @(negedge clock);
        total_cnt++;
        if (check_busy !== 1'b1) $display("FAIL rst_pre_busy: got busy=%0b want 1", check_busy);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        m_grid = '0; m_given = '0; m_ci = 0; m_cj = 0; m_uv = 0;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        total_cnt++;
        if (solved !== 1'b0 || check_busy !== 1'b0)
            $display("FAIL rst_after: got solved=%0b busy=%0b, want 0 0", solved, check_busy);
        else pass_cnt++;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        test_cursor();
        test_write_protect();
        test_solve();
        test_write_solve();
        test_load_vs_key();
        test_undo();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
